// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for a word-addressed 16-bit data memory.
// Optional LSU_SIGN_EXT_EN macro enables sign extension of byte loads when req_unsigned=0.
module load_store_unit #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic              size_q, size_d;
   logic              lane_q, lane_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_en_q, mem_write_en_d;
   logic              resp_valid_q, resp_valid_d;

   logic [BYTE_W-1:0] byte_sel;
   logic              ext_bit;
   logic [DATA_W-1:0] load_word;
   logic [DATA_W-1:0] merged_word;

`ifdef LSU_SIGN_EXT_EN
   logic uns_q, uns_d;
`else
   logic unused_unsigned;
   assign unused_unsigned = req_unsigned;
`endif

   // Byte lane selection, extension and read-modify-write merge from live read data
   always_comb begin
      byte_sel = lane_q ? mem_read_data[DATA_W-1:BYTE_W] : mem_read_data[BYTE_W-1:0];
`ifdef LSU_SIGN_EXT_EN
      ext_bit = ~uns_q & byte_sel[BYTE_W-1];
`else
      ext_bit = 1'b0;
`endif
      load_word   = size_q ? mem_read_data : {{(DATA_W-BYTE_W){ext_bit}}, byte_sel};
      merged_word = lane_q ? {wdata_q[BYTE_W-1:0], mem_read_data[BYTE_W-1:0]}
                           : {mem_read_data[DATA_W-1:BYTE_W], wdata_q[BYTE_W-1:0]};
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      we_d           = we_q;
      size_d         = size_q;
      lane_d         = lane_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      mem_read_d     = 1'b0;
      mem_write_en_d = 1'b0;
      resp_valid_d   = 1'b0;
`ifdef LSU_SIGN_EXT_EN
      uns_d          = uns_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               lane_d  = req_addr[0];
               addr_d  = {1'b0, req_addr[ADDR_W-1:1]};
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
`ifdef LSU_SIGN_EXT_EN
               uns_d   = req_unsigned;
`endif
               if (req_size && req_addr[0]) begin
                  err_d        = 1'b1;
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
               end else if (!req_we || !req_size) begin
                  state_d    = READ;
                  mem_read_d = 1'b1;
               end else begin
                  state_d        = WRITE;
                  mem_write_en_d = 1'b1;
               end
            end
         end
         READ: begin
            if (we_q) begin
               wdata_d        = merged_word;
               state_d        = WRITE;
               mem_write_en_d = 1'b1;
            end else begin
               rdata_d      = load_word;
               state_d      = RESP;
               resp_valid_d = 1'b1;
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end else begin
               resp_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         we_q           <= 1'b0;
         size_q         <= 1'b0;
         lane_q         <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
         mem_read_q     <= 1'b0;
         mem_write_en_q <= 1'b0;
         resp_valid_q   <= 1'b0;
`ifdef LSU_SIGN_EXT_EN
         uns_q          <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         we_q           <= we_d;
         size_q         <= size_d;
         lane_q         <= lane_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         rdata_q        <= rdata_d;
         err_q          <= err_d;
         mem_read_q     <= mem_read_d;
         mem_write_en_q <= mem_write_en_d;
         resp_valid_q   <= resp_valid_d;
`ifdef LSU_SIGN_EXT_EN
         uns_q          <= uns_d;
`endif
      end
   end

   // Ready is a pure state decode, held low while reset is asserted
   assign req_ready       = rst_n & (state_q == IDLE);
   assign resp_valid      = resp_valid_q;
   assign resp_rdata      = rdata_q;
   assign resp_err        = err_q;
   assign mem_access_addr = addr_q;
   assign mem_write_data  = wdata_q;
   assign mem_write_en    = mem_write_en_q;
   assign mem_read        = mem_read_q;

endmodule
